// File: rtl/block_fill_server.sv
// Round-robin block fetch responder for the L1 block-cache miss path.
// Define FILL_SERVER_STATS_EN to add saturating request / out-of-range counters.
module block_fill_server #(
  parameter int N           = 4,
  parameter int CHUNK_WIDTH = 16,
  parameter int COORD_W     = $clog2(CHUNK_WIDTH) + 1,
  parameter int BLOCK_W     = 4,
  parameter int MEM_LAT     = 2,
  parameter int ADDR_W      = 3 * $clog2(CHUNK_WIDTH)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [N-1:0]                  req_valid,
  input  logic [N-1:0][3*COORD_W-1:0]   req_pos,
  output logic [N-1:0]                  req_ready,
  output logic [N-1:0]                  resp_valid,
  output logic [3*COORD_W-1:0]          resp_pos,
  output logic [BLOCK_W-1:0]            resp_block,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [BLOCK_W-1:0]            mem_rdata
`ifdef FILL_SERVER_STATS_EN
  ,
  output logic [15:0]                   stat_req,
  output logic [15:0]                   stat_oob
`endif
);

  localparam int LG    = $clog2(CHUNK_WIDTH);
  localparam int PW    = 3 * COORD_W;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [BLOCK_W-1:0] BLOCK_AIR = '0;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESPOND
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_q, port_q, grant;
  logic [PW-1:0]    pos_q, gpos;
  logic [CNT_W-1:0] cnt_q;
  logic             any_req, in_range;
  logic             accept, last;

  // Coordinates are in range exactly when every bit above the index bits is clear.
  function automatic logic coord_ok(input logic [COORD_W-1:0] c);
    return c[COORD_W-1:LG] == '0;
  endfunction

  always_comb begin
    int idx;
    idx     = 0;
    grant   = rr_q;
    any_req = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(rr_q) + i) % N;
      if (req_valid[idx]) begin
        grant   = PTR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign gpos     = req_pos[grant];
  assign in_range = coord_ok(gpos[PW-1 -: COORD_W])
                 && coord_ok(gpos[2*COORD_W-1 -: COORD_W])
                 && coord_ok(gpos[COORD_W-1:0]);

  assign last   = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign accept = (state_q == IDLE) && any_req && !rst_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = in_range ? ISSUE : RESPOND;
      ISSUE:   state_d = WAIT;
      WAIT:    if (last) state_d = RESPOND;
      RESPOND: state_d = IDLE;
    endcase
  end

  assign req_ready  = accept ? (N'(1) << grant) : '0;
  assign resp_valid = (state_q == RESPOND && !rst_in)
                    ? (N'(1) << port_q) : '0;
  assign mem_en     = (state_q == ISSUE) && !rst_in;
  assign mem_addr   = mem_en ? {pos_q[LG-1:0],
                                pos_q[COORD_W +: LG],
                                pos_q[2*COORD_W +: LG]} : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      rr_q       <= PTR_W'(N - 1);
      port_q     <= '0;
      pos_q      <= '0;
      cnt_q      <= '0;
      resp_pos   <= '0;
      resp_block <= BLOCK_AIR;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        rr_q   <= grant;
        port_q <= grant;
        pos_q  <= gpos;
        if (!in_range) begin
          resp_pos   <= gpos;
          resp_block <= BLOCK_AIR;
        end
      end
      // Response registers only move on entry to RESPOND, so they hold otherwise.
      if (state_q == WAIT && last) begin
        resp_pos   <= pos_q;
        resp_block <= mem_rdata;
      end
    end
  end

`ifdef FILL_SERVER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_req <= '0;
      stat_oob <= '0;
    end else if (accept) begin
      if (stat_req != 16'hFFFF) stat_req <= stat_req + 16'd1;
      if (!in_range && stat_oob != 16'hFFFF)
        stat_oob <= stat_oob + 16'd1;
    end
  end
`endif

endmodule
